// File: rtl/seq_shift_if.sv
// seq_shift_if: handshake and data bundle for seq_shift_unit.
// The master drives the request side (start/din/amt/dir/mode); the slave
// (the shifter) drives busy/done/out/ser_out.
// Optional macro SEQ_SHIFT_STICKY_EN adds the sticky output.
interface seq_shift_if #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 5
);
    logic             start;
    logic [WIDTH-1:0] din;
    logic [AMT_W-1:0] amt;
    logic             dir;
    logic [1:0]       mode;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out;
    logic             ser_out;
`ifdef SEQ_SHIFT_STICKY_EN
    logic             sticky;

    modport master (
        output start, din, amt, dir, mode,
        input  busy, done, out, ser_out, sticky
    );

    modport slave (
        input  start, din, amt, dir, mode,
        output busy, done, out, ser_out, sticky
    );
`else
    modport master (
        output start, din, amt, dir, mode,
        input  busy, done, out, ser_out
    );

    modport slave (
        input  start, din, amt, dir, mode,
        output busy, done, out, ser_out
    );
`endif
endinterface

// File: rtl/seq_shift_unit.sv
// seq_shift_unit: multi-cycle shifter, one bit position per clock.
// Directions: right/left. Modes: 00 arithmetic, 01 logical, 10 rotate,
// 11 logical. Shift/arith amounts are clamped to WIDTH; rotates are not.
// ser_out holds the last bit moved out of the word.
// Optional macro SEQ_SHIFT_STICKY_EN adds a sticky OR of all bits shifted
// out (arithmetic/logical only), used for rounding in the divide path.
// AMT_W is expected to be at most 32.
module seq_shift_unit #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 5
) (
    input logic        clk,
    input logic        reset,
    seq_shift_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    localparam logic [31:0]      WIDTH_U = 32'(WIDTH);
    localparam logic [AMT_W-1:0] CNT_ONE = AMT_W'(1);
    localparam logic [AMT_W-1:0] CNT_ZERO = AMT_W'(0);

    // Shift amount actually performed: clamped for shifts, raw for rotates.
    function automatic logic [AMT_W-1:0] eff_amount(
        input logic [AMT_W-1:0] a,
        input logic [1:0]       m
    );
        logic [31:0]      a_ext;
        logic [AMT_W-1:0] r;
        a_ext = 32'(a);
        if (m == 2'b10) begin
            r = a;
        end else if (a_ext > WIDTH_U) begin
            r = WIDTH_U[AMT_W-1:0];
        end else begin
            r = a;
        end
        return r;
    endfunction

    // One-position move; result is {bit moved out, new word}.
    function automatic logic [WIDTH:0] shift_step(
        input logic [WIDTH-1:0] w,
        input logic             d,
        input logic [1:0]       m
    );
        logic           fill;
        logic [WIDTH:0] r;
        if (!d) begin
            case (m)
                2'b00:   fill = w[WIDTH-1];
                2'b10:   fill = w[0];
                default: fill = 1'b0;
            endcase
            r = {w[0], fill, w[WIDTH-1:1]};
        end else begin
            if (m == 2'b10) begin
                fill = w[WIDTH-1];
            end else begin
                fill = 1'b0;
            end
            r = {w[WIDTH-1], w[WIDTH-2:0], fill};
        end
        return r;
    endfunction

    state_e           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             ser_q, ser_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic [1:0]       mode_q, mode_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [AMT_W-1:0] eff_s;
    logic [WIDTH:0]   step_s;
`ifdef SEQ_SHIFT_STICKY_EN
    logic             sticky_q, sticky_d;
`endif

    assign eff_s  = eff_amount(bus.amt, bus.mode);
    assign step_s = shift_step(out_q, dir_q, mode_q);

    // Next-state, datapath and registered-flag logic.
    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        ser_d    = ser_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        mode_d   = mode_q;
`ifdef SEQ_SHIFT_STICKY_EN
        sticky_d = sticky_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    out_d  = bus.din;
                    ser_d  = 1'b0;
                    dir_d  = bus.dir;
                    mode_d = bus.mode;
                    cnt_d  = eff_s;
`ifdef SEQ_SHIFT_STICKY_EN
                    sticky_d = 1'b0;
`endif
                    if (eff_s != CNT_ZERO) begin
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                out_d = step_s[WIDTH-1:0];
                ser_d = step_s[WIDTH];
                cnt_d = cnt_q - CNT_ONE;
`ifdef SEQ_SHIFT_STICKY_EN
                if (mode_q != 2'b10) begin
                    sticky_d = sticky_q | step_s[WIDTH];
                end else begin
                    sticky_d = sticky_q;
                end
`endif
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_SHIFT);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers; reset aborts any operation at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            out_q    <= '0;
            ser_q    <= 1'b0;
            cnt_q    <= '0;
            dir_q    <= 1'b0;
            mode_q   <= 2'b00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SEQ_SHIFT_STICKY_EN
            sticky_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            ser_q    <= ser_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            mode_q   <= mode_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef SEQ_SHIFT_STICKY_EN
            sticky_q <= sticky_d;
`endif
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.out     = out_q;
    assign bus.ser_out = ser_q;
`ifdef SEQ_SHIFT_STICKY_EN
    assign bus.sticky  = sticky_q;
`endif

endmodule

// File: tb/tb_seq_shift_unit.sv
// tb_seq_shift_unit: table vectors, handshake corner sequences and random
// operations checked against a word-level reference model.
module tb_seq_shift_unit;

    localparam int W  = 16;
    localparam int AW = 5;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    seq_shift_if #(.WIDTH(W), .AMT_W(AW)) sif ();

    seq_shift_unit #(.WIDTH(W), .AMT_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif.slave)
    );

    typedef struct {
        logic [15:0] din;
        logic [4:0]  amt;
        logic        dir;
        logic [1:0]  mode;
        logic [15:0] eout;
        logic        eser;
        logic        estk;
        int          elat;
    } vec_t;

    vec_t tbl[9];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time limit so the bench never hangs.
    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference: whole-word arithmetic from the operation definition.
    task automatic model(input logic [15:0] d, input logic [4:0] a, input logic dr,
                         input logic [1:0] m, output logic [15:0] o, output logic s,
                         output logic st, output int k);
        int          n;
        int          r;
        logic [15:0] mask;
        n = int'(a);
        if (m != 2'b10 && n > W) n = W;
        k = n;
        o = d; s = 1'b0; st = 1'b0;
        if (n != 0) begin
            if (m == 2'b10) begin
                r = n % W;
                if (!dr) begin
                    o = (r == 0) ? d : ((d >> r) | (d << (W - r)));
                    s = d[(n - 1) % W];
                end else begin
                    o = (r == 0) ? d : ((d << r) | (d >> (W - r)));
                    s = d[(W - r) % W];
                end
            end else if (!dr) begin
                if (m == 2'b00) o = 16'($signed(d) >>> n);
                else            o = d >> n;
                s    = d[n - 1];
                mask = ~(16'hFFFF << n);
                st   = |(d & mask);
            end else begin
                o    = d << n;
                s    = d[W - n];
                mask = ~(16'hFFFF >> n);
                st   = |(d & mask);
            end
        end
    endtask

    // Issue one operation at a negedge and check its result and timing.
    // glitch>0 pulses start during SHIFT at that cycle; chain=1 returns at
    // the done cycle so the caller can start the next op from DONE.
    task automatic run_op(input string nm, input logic [15:0] d, input logic [4:0] a,
                          input logic dr, input logic [1:0] m, input logic [15:0] eo,
                          input logic es, input logic est, input int elat,
                          input int glitch, input bit chain);
        int   lat;
        int   bcnt;
        logic got;
        sif.start = 1'b1; sif.din = d; sif.amt = a; sif.dir = dr; sif.mode = m;
        @(posedge clk);
        #1;
        sif.start = 1'b0;
        sif.din   = 16'($urandom);
        sif.amt   = 5'($urandom);
        sif.dir   = 1'($urandom);
        sif.mode  = 2'($urandom);
        lat = 0; bcnt = 0; got = 1'b0;
        while (!got && lat < 100) begin
            @(negedge clk);
            lat++;
            sif.start = (glitch != 0 && lat == glitch) ? 1'b1 : 1'b0;
            if (sif.busy) bcnt++;
            if (sif.done) got = 1'b1;
        end
        sif.start = 1'b0;
        chk({nm, " done_seen"}, 32'(got), 32'(1));
        chk({nm, " latency"}, 32'(lat), 32'(elat));
        chk({nm, " busy_cycles"}, 32'(bcnt), 32'(elat - 1));
        chk({nm, " out"}, 32'(sif.out), 32'(eo));
        chk({nm, " ser_out"}, 32'(sif.ser_out), 32'(es));
`ifdef SEQ_SHIFT_STICKY_EN
        chk({nm, " sticky"}, 32'(sif.sticky), 32'(est));
`else
        if (est === 1'bx) $display("sticky expectation unknown for %s", nm);
`endif
        if (!chain) begin
            @(negedge clk);
            chk({nm, " done_pulse_len"}, 32'({sif.done, sif.busy}), 32'(0));
            chk({nm, " out_hold"}, 32'(sif.out), 32'(eo));
        end
    endtask

    initial begin
        logic [15:0] eo;
        logic        es;
        logic        est;
        int          k;
        int          dseen;
        logic [15:0] rd;
        logic [4:0]  ra;
        logic        rdir;
        logic [1:0]  rm;

        vectors = 0;
        miscompares = 0;

        tbl[0] = '{16'hF0F0, 5'd4,  1'b0, 2'b00, 16'hFF0F, 1'b0, 1'b0, 5};
        tbl[1] = '{16'hF0F0, 5'd5,  1'b0, 2'b01, 16'h0787, 1'b1, 1'b1, 6};
        tbl[2] = '{16'h8001, 5'd20, 1'b1, 2'b10, 16'h0018, 1'b0, 1'b0, 21};
        tbl[3] = '{16'h8000, 5'd31, 1'b0, 2'b00, 16'hFFFF, 1'b1, 1'b1, 17};
        tbl[4] = '{16'h1234, 5'd0,  1'b0, 2'b00, 16'h1234, 1'b0, 1'b0, 1};
        tbl[5] = '{16'hABCD, 5'd16, 1'b0, 2'b10, 16'hABCD, 1'b1, 1'b0, 17};
        tbl[6] = '{16'h00FF, 5'd3,  1'b1, 2'b11, 16'h07F8, 1'b0, 1'b0, 4};
        tbl[7] = '{16'hC003, 5'd2,  1'b1, 2'b00, 16'h000C, 1'b1, 1'b1, 3};
        tbl[8] = '{16'h7FFF, 5'd17, 1'b0, 2'b01, 16'h0000, 1'b0, 1'b1, 17};

        reset = 1'b1;
        sif.start = 1'b0; sif.din = '0; sif.amt = '0; sif.dir = 1'b0; sif.mode = 2'b00;
        repeat (2) @(negedge clk);
        chk("reset out", 32'(sif.out), 32'(0));
        chk("reset flags", 32'({sif.busy, sif.done, sif.ser_out}), 32'(0));
        reset = 1'b0;
        @(negedge clk);

        // Table vectors.
        for (int i = 0; i < 9; i++) begin
            run_op($sformatf("tbl%0d", i), tbl[i].din, tbl[i].amt, tbl[i].dir, tbl[i].mode,
                   tbl[i].eout, tbl[i].eser, tbl[i].estk, tbl[i].elat, 0, 1'b0);
        end

        // start pulsed during SHIFT must be ignored.
        run_op("ignore_start", 16'h00F0, 5'd6, 1'b0, 2'b01, 16'h0003, 1'b1, 1'b1, 7, 2, 1'b0);

        // start presented in DONE loads the next op with no IDLE cycle.
        run_op("chain_a", 16'h0F00, 5'd2, 1'b0, 2'b01, 16'h03C0, 1'b0, 1'b0, 3, 0, 1'b1);
        run_op("chain_b", 16'h0001, 5'd3, 1'b1, 2'b10, 16'h0008, 1'b0, 1'b0, 4, 0, 1'b0);

        // Reset three cycles into an 8-step operation.
        sif.start = 1'b1; sif.din = 16'hFFFF; sif.amt = 5'd8; sif.dir = 1'b0; sif.mode = 2'b01;
        @(posedge clk);
        #1;
        sif.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_reset busy", 32'(sif.busy), 32'(1));
        #2;
        reset = 1'b1;
        #1;
        chk("midreset out", 32'(sif.out), 32'(0));
        chk("midreset flags", 32'({sif.busy, sif.done, sif.ser_out}), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        dseen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (sif.done || sif.busy) dseen++;
        end
        chk("midreset no_done", 32'(dseen), 32'(0));

        // Random operations against the reference model.
        for (int i = 0; i < 30; i++) begin
            rd   = 16'($urandom);
            ra   = 5'($urandom_range(0, 31));
            rdir = 1'($urandom);
            rm   = 2'($urandom);
            model(rd, ra, rdir, rm, eo, es, est, k);
            run_op($sformatf("rnd%0d", i), rd, ra, rdir, rm, eo, es, est, k + 1, 0,
                   1'($urandom_range(0, 1)));
        end
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
